// File: rtl/axi_dw_ctrl_pkg.sv
// Shared types and helpers for the upsizing read lane controller.
package axi_dw_ctrl_pkg;
    import axi_pkg::*;

    // Offsets are carried at 8 bits, enough for any wide port up to 2048 bits.
    typedef struct packed {
        logic       valid;
        logic       err;
        logic [2:0] size;
        logic [1:0] burst;
        logic [7:0] remaining;
        logic [7:0] offset;
    } rd_slot_t;

    function automatic logic [7:0] next_offset(input logic [7:0] offset,
                                               input logic [2:0] size,
                                               input logic [1:0] burst);
        if (burst == BURST_FIXED) begin
            return offset;
        end
        return offset + (8'd1 << size);
    endfunction

    function automatic int unsigned calc_off_w(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic int unsigned calc_lane_w(input int unsigned mst_width,
                                                input int unsigned slv_width);
        int d;
        d = int'(calc_off_w(mst_width)) - int'(calc_off_w(slv_width));
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/axi_pkg.sv
// Minimal AXI encodings shared by the data-width converter blocks.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

endpackage

// File: rtl/axi_dw_rd_age_matrix.sv
// Age matrix for read slots: row i holds the slots older than slot i.
module axi_dw_rd_age_matrix #(
    parameter int unsigned NumSlots = 4,
    parameter int unsigned IdxW     = (NumSlots > 1) ? $clog2(NumSlots) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                alloc_i,
    input  logic [IdxW-1:0]     alloc_idx_i,
    input  logic [NumSlots-1:0] valid_i,
    input  logic                release_i,
    input  logic [IdxW-1:0]     release_idx_i,
    input  logic [NumSlots-1:0] mask_i,
    output logic                found_o,
    output logic [IdxW-1:0]     oldest_idx_o
);

    logic [NumSlots-1:0][NumSlots-1:0] age_q, age_d;
    logic [NumSlots-1:0]               is_oldest;

    always_comb begin
        age_d = age_q;
        if (release_i) begin
            age_d[release_idx_i] = '0;
        end
        if (alloc_i) begin
            // A new slot is younger than everything, so stale column bits go.
            for (int r = 0; r < NumSlots; r++) begin
                age_d[r][alloc_idx_i] = 1'b0;
            end
            age_d[alloc_idx_i] = valid_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    for (genvar gi = 0; gi < NumSlots; gi++) begin : g_oldest
        assign is_oldest[gi] = mask_i[gi] && ((age_q[gi] & mask_i) == '0);
    end

    always_comb begin
        oldest_idx_o = '0;
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (is_oldest[i]) begin
                oldest_idx_o = IdxW'(i);
            end
        end
    end

    assign found_o = |is_oldest;

endmodule

// File: rtl/axi_dw_rd_lane_ctrl.sv
// Read-side lane sequencer for the upsizing width converter.
// Optional high-water mark output enabled by AXI_DW_RD_LANE_CTRL_HWM_EN.
module axi_dw_rd_lane_ctrl
    import axi_pkg::*;
    import axi_dw_ctrl_pkg::*;
#(
    parameter int unsigned MaxReads         = 4,
    parameter int unsigned SlvPortDataWidth = 32,
    parameter int unsigned MstPortDataWidth = 64,
    parameter int unsigned AddrWidth        = 32,
    parameter int unsigned IdWidth          = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  ar_valid_i,
    output logic                                  ar_ready_o,
    input  logic [IdWidth-1:0]                    ar_id_i,
    input  logic [AddrWidth-1:0]                  ar_addr_i,
    input  logic [7:0]                            ar_len_i,
    input  logic [2:0]                            ar_size_i,
    input  logic [1:0]                            ar_burst_i,
    input  logic                                  beat_valid_i,
    input  logic [IdWidth-1:0]                    beat_id_i,
    input  logic                                  beat_ready_i,
    output logic                                  hit_o,
    output logic [calc_lane_w(MstPortDataWidth, SlvPortDataWidth)-1:0] lane_o,
    output logic                                  pop_o,
    output logic                                  last_o,
    output logic                                  err_o,
    output logic [$clog2(MaxReads):0]             busy_o
`ifdef AXI_DW_RD_LANE_CTRL_HWM_EN
    ,
    output logic [$clog2(MaxReads):0]             hwm_o
`endif
);

    localparam int unsigned SlvOffW = calc_off_w(SlvPortDataWidth);
    localparam int unsigned MstOffW = calc_off_w(MstPortDataWidth);
    localparam int unsigned IdxW    = (MaxReads > 1) ? $clog2(MaxReads) : 1;
    localparam int unsigned CntW    = $clog2(MaxReads) + 1;
    localparam logic [7:0]  OffMask = 8'((1 << MstOffW) - 1);

    rd_slot_t             slot_q [MaxReads];
    rd_slot_t             slot_d [MaxReads];
    logic [IdWidth-1:0]   id_q   [MaxReads];
    logic [IdWidth-1:0]   id_d   [MaxReads];

    logic [MaxReads-1:0]  valid_vec;
    logic [MaxReads-1:0]  match_vec;
    logic [IdxW-1:0]      alloc_idx;
    logic [IdxW-1:0]      hit_idx;
    logic                 found;
    logic                 alloc;
    logic                 fire;
    logic                 release_slot;
    rd_slot_t             sel;
    logic                 sel_last;
    logic [7:0]           nxt_off;
    logic                 pop_raw;
    logic [CntW-1:0]      busy_cnt;
    logic [CntW-1:0]      busy_next;
    logic                 unused_addr;

    assign unused_addr = ^ar_addr_i[AddrWidth-1:MstOffW];

    for (genvar gi = 0; gi < MaxReads; gi++) begin : g_slot_vec
        assign valid_vec[gi] = slot_q[gi].valid;
        assign match_vec[gi] = slot_q[gi].valid && (id_q[gi] == beat_id_i);
    end

    assign ar_ready_o = ~&valid_vec;
    assign alloc      = ar_valid_i && ar_ready_o;

    always_comb begin
        alloc_idx = '0;
        for (int i = MaxReads - 1; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                alloc_idx = IdxW'(i);
            end
        end
    end

    axi_dw_rd_age_matrix #(
        .NumSlots (MaxReads),
        .IdxW     (IdxW)
    ) u_age (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .alloc_i       (alloc),
        .alloc_idx_i   (alloc_idx),
        .valid_i       (valid_vec),
        .release_i     (release_slot),
        .release_idx_i (hit_idx),
        .mask_i        (match_vec),
        .found_o       (found),
        .oldest_idx_o  (hit_idx)
    );

    assign sel      = slot_q[hit_idx];
    assign sel_last = (sel.remaining == 8'd0);
    assign nxt_off  = next_offset(sel.offset, sel.size, sel.burst) & OffMask;

    // Error and FIXED bursts drain one wide beat per narrow beat.
    always_comb begin
        if (sel.err || (sel.burst == BURST_FIXED)) begin
            pop_raw = 1'b1;
        end else begin
            pop_raw = (nxt_off == 8'd0) || sel_last;
        end
    end

    assign hit_o        = beat_valid_i && found;
    assign lane_o       = (hit_o && !sel.err) ? sel.offset[MstOffW-1:SlvOffW] : '0;
    assign pop_o        = hit_o && pop_raw;
    assign last_o       = hit_o && sel_last;
    assign err_o        = hit_o && sel.err;
    assign fire         = hit_o && beat_ready_i;
    assign release_slot = fire && sel_last;

    always_comb begin
        for (int i = 0; i < MaxReads; i++) begin
            slot_d[i] = slot_q[i];
            id_d[i]   = id_q[i];
        end
        if (fire) begin
            if (sel_last) begin
                slot_d[hit_idx].valid = 1'b0;
            end else begin
                slot_d[hit_idx].remaining = sel.remaining - 8'd1;
                slot_d[hit_idx].offset    = nxt_off;
            end
        end
        if (alloc) begin
            slot_d[alloc_idx] = '{
                valid:     1'b1,
                err:       (ar_burst_i == BURST_WRAP) || (ar_size_i > 3'(SlvOffW)),
                size:      ar_size_i,
                burst:     ar_burst_i,
                remaining: ar_len_i,
                offset:    8'(ar_addr_i[MstOffW-1:0])
            };
            id_d[alloc_idx] = ar_id_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MaxReads; i++) begin
                slot_q[i] <= '0;
                id_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < MaxReads; i++) begin
                slot_q[i] <= slot_d[i];
                id_q[i]   <= id_d[i];
            end
        end
    end

    always_comb begin
        busy_cnt  = '0;
        busy_next = '0;
        for (int i = 0; i < MaxReads; i++) begin
            busy_cnt  = busy_cnt + CntW'(slot_q[i].valid);
            busy_next = busy_next + CntW'(slot_d[i].valid);
        end
    end

    assign busy_o = busy_cnt;

`ifdef AXI_DW_RD_LANE_CTRL_HWM_EN
    logic [CntW-1:0] hwm_q, hwm_d;

    assign hwm_d = (busy_next > hwm_q) ? busy_next : hwm_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm_o = hwm_q;
`else
    logic unused_busy_next;
    assign unused_busy_next = ^busy_next;
`endif

    // A narrow beat may only be accepted against a tracked transaction.
    beat_ready_needs_hit: assert property (
        @(posedge clk_i) disable iff (!rst_ni) beat_ready_i |-> hit_o
    );

endmodule

// File: tb/tb_axi_dw_rd_lane_ctrl.sv
// Directed bench for axi_dw_rd_lane_ctrl (32->64, four slots).
module tb_axi_dw_rd_lane_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ar_valid;
    logic       ar_ready;
    logic [3:0] ar_id;
    logic [31:0] ar_addr;
    logic [7:0] ar_len;
    logic [2:0] ar_size;
    logic [1:0] ar_burst;
    logic       beat_valid;
    logic [3:0] beat_id;
    logic       beat_ready;
    logic       hit;
    logic [0:0] lane;
    logic       pop;
    logic       last;
    logic       err;
    logic [2:0] busy;
`ifdef AXI_DW_RD_LANE_CTRL_HWM_EN
    logic [2:0] hwm;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axi_dw_rd_lane_ctrl #(
        .MaxReads         (4),
        .SlvPortDataWidth (32),
        .MstPortDataWidth (64),
        .AddrWidth        (32),
        .IdWidth          (4)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .ar_valid_i   (ar_valid),
        .ar_ready_o   (ar_ready),
        .ar_id_i      (ar_id),
        .ar_addr_i    (ar_addr),
        .ar_len_i     (ar_len),
        .ar_size_i    (ar_size),
        .ar_burst_i   (ar_burst),
        .beat_valid_i (beat_valid),
        .beat_id_i    (beat_id),
        .beat_ready_i (beat_ready),
        .hit_o        (hit),
        .lane_o       (lane),
        .pop_o        (pop),
        .last_o       (last),
        .err_o        (err),
`ifdef AXI_DW_RD_LANE_CTRL_HWM_EN
        .hwm_o        (hwm),
`endif
        .busy_o       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        @(negedge clk);
        ar_valid = 1'b1;
        ar_id    = id;
        ar_addr  = addr;
        ar_len   = len;
        ar_size  = size;
        ar_burst = burst;
        @(posedge clk);
        #1;
        ar_valid = 1'b0;
        $display("AR id=%0d addr=%0h len=%0d size=%0d burst=%0d busy=%0d", id, addr, len, size, burst, busy);
    endtask

    task automatic beat(input string tag, input logic [3:0] id, input logic exp_lane,
                        input logic exp_pop, input logic exp_last, input logic exp_err);
        @(negedge clk);
        beat_valid = 1'b1;
        beat_id    = id;
        #1;
        check({tag, ".hit"},  32'(hit),  32'd1);
        check({tag, ".lane"}, 32'(lane), 32'(exp_lane));
        check({tag, ".pop"},  32'(pop),  32'(exp_pop));
        check({tag, ".last"}, 32'(last), 32'(exp_last));
        check({tag, ".err"},  32'(err),  32'(exp_err));
        $display("BEAT %s id=%0d hit=%0d lane=%0d pop=%0d last=%0d err=%0d", tag, id, hit, lane, pop, last, err);
        beat_ready = (hit === 1'b1);
        @(posedge clk);
        #1;
        beat_valid = 1'b0;
        beat_ready = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        ar_valid   = 1'b0;
        ar_id      = '0;
        ar_addr    = '0;
        ar_len     = '0;
        ar_size    = '0;
        ar_burst   = '0;
        beat_valid = 1'b0;
        beat_id    = '0;
        beat_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst.ar_ready", 32'(ar_ready), 32'd1);
        check("rst.busy",     32'(busy),     32'd0);
        check("rst.hit",      32'(hit),      32'd0);
        check("rst.pop",      32'(pop),      32'd0);
        check("rst.last",     32'(last),     32'd0);
        check("rst.err",      32'(err),      32'd0);
        check("rst.lane",     32'(lane),     32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        beat_valid = 1'b1;
        beat_id    = 4'd1;
        #1;
        check("empty.hit", 32'(hit), 32'd0);
        check("empty.pop", 32'(pop), 32'd0);
        beat_valid = 1'b0;

        // INCR 32->64, offset 4: lanes 1,0,1,0
        issue_ar(4'd1, 32'h04, 8'd3, 3'd2, 2'b01);
        check("incr.busy", 32'(busy), 32'd1);
        beat("incr0", 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        beat("incr1", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        beat("incr2", 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        beat("incr3", 4'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("incr.freed", 32'(busy), 32'd0);

        // FIXED keeps its lane and pops every beat
        issue_ar(4'd1, 32'h04, 8'd1, 3'd2, 2'b00);
        beat("fix0", 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        beat("fix1", 4'd1, 1'b1, 1'b1, 1'b1, 1'b0);

        // WRAP is unsupported
        issue_ar(4'd1, 32'h04, 8'd3, 3'd2, 2'b10);
        beat("wrap0", 4'd1, 1'b0, 1'b1, 1'b0, 1'b1);
        beat("wrap1", 4'd1, 1'b0, 1'b1, 1'b0, 1'b1);
        beat("wrap2", 4'd1, 1'b0, 1'b1, 1'b0, 1'b1);
        beat("wrap3", 4'd1, 1'b0, 1'b1, 1'b1, 1'b1);

        // Size wider than the narrow port is unsupported
        issue_ar(4'd6, 32'h00, 8'd0, 3'd3, 2'b01);
        beat("big0", 4'd6, 1'b0, 1'b1, 1'b1, 1'b1);

        // Sub-width INCR: 2-byte beats from offset 6
        issue_ar(4'd4, 32'h06, 8'd1, 3'd1, 2'b01);
        beat("half0", 4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        beat("half1", 4'd4, 1'b0, 1'b1, 1'b1, 1'b0);
        check("half.busy", 32'(busy), 32'd0);

        // Interleaved IDs, id 5 served first
        issue_ar(4'd3, 32'h00, 8'd1, 3'd2, 2'b01);
        issue_ar(4'd5, 32'h04, 8'd1, 3'd2, 2'b01);
        beat("id5a", 4'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        beat("id5b", 4'd5, 1'b0, 1'b1, 1'b1, 1'b0);
        check("ilv.busy", 32'(busy), 32'd1);
        beat("id3a", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        beat("id3b", 4'd3, 1'b1, 1'b1, 1'b1, 1'b0);

        // Fill the table with same-ID transactions
        issue_ar(4'd2, 32'h04, 8'd1, 3'd2, 2'b01);
        issue_ar(4'd2, 32'h00, 8'd0, 3'd2, 2'b01);
        issue_ar(4'd2, 32'h04, 8'd0, 3'd2, 2'b01);
        issue_ar(4'd2, 32'h00, 8'd0, 3'd2, 2'b01);
        check("full.ar_ready", 32'(ar_ready), 32'd0);
        check("full.busy",     32'(busy),     32'd4);
`ifdef AXI_DW_RD_LANE_CTRL_HWM_EN
        check("full.hwm",      32'(hwm),      32'd4);
`endif
        beat("q0a", 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        check("full.still", 32'(ar_ready), 32'd0);
        beat("q0b", 4'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        check("free.ar_ready", 32'(ar_ready), 32'd1);
        check("free.busy",     32'(busy),     32'd3);

        // Allocate and release in the same cycle
        @(negedge clk);
        ar_valid   = 1'b1;
        ar_id      = 4'd2;
        ar_addr    = 32'h04;
        ar_len     = 8'd0;
        ar_size    = 3'd2;
        ar_burst   = 2'b01;
        beat_valid = 1'b1;
        beat_id    = 4'd2;
        #1;
        check("both.hit",  32'(hit),  32'd1);
        check("both.lane", 32'(lane), 32'd0);
        check("both.last", 32'(last), 32'd1);
        beat_ready = (hit === 1'b1);
        @(posedge clk);
        #1;
        ar_valid   = 1'b0;
        beat_valid = 1'b0;
        beat_ready = 1'b0;
        check("both.busy", 32'(busy), 32'd3);
        $display("BOTH alloc+release busy=%0d", busy);
        beat("q2", 4'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        beat("q3", 4'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        beat("qn", 4'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        check("drain.busy", 32'(busy), 32'd0);

        // Reset with three slots busy
        issue_ar(4'd7, 32'h00, 8'd3, 3'd2, 2'b01);
        issue_ar(4'd7, 32'h04, 8'd3, 3'd2, 2'b01);
        issue_ar(4'd7, 32'h00, 8'd3, 3'd2, 2'b01);
        check("pre.busy", 32'(busy), 32'd3);
        @(negedge clk);
        beat_valid = 1'b1;
        beat_id    = 4'd7;
        #1;
        check("pre.hit", 32'(hit), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst.busy",     32'(busy),     32'd0);
        check("mrst.ar_ready", 32'(ar_ready), 32'd1);
        check("mrst.hit",      32'(hit),      32'd0);
`ifdef AXI_DW_RD_LANE_CTRL_HWM_EN
        check("mrst.hwm",      32'(hwm),      32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post.hit", 32'(hit), 32'd0);
        check("post.pop", 32'(pop), 32'd0);
        $display("RESET mid-op busy=%0d hit=%0d", busy, hit);
        beat_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
